cdb_arbiter: RTL and testbench

//  Round-robin arbiter/scheduler for the single common data bus (CDB). Shares the bus between
//  N_SRC result producers (ALU RS, branch unit, LSB load port, ...). One result per cycle goes
//  out to the reorder buffer and the reservation stations through a registered broadcast stage.
//  Per-source valid/ready handshake; squashes everything on a branch-mispredict flush.

---
 rtl/cdb_arbiter.sv | 97 +++++++++
 tb/tb_cdb_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin scheduler for the single common data bus: picks one ready producer per cycle
// and drives its result onto a registered broadcast stage toward the ROB and reservation stations.
module cdb_arbiter #(
    parameter int N_SRC   = 3,
    parameter int SRC_BIT = 2,
    parameter int ROB_BIT = 4,
    parameter int DAT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush_i,
    input  logic [N_SRC-1:0]         req_vld_i,
    input  logic [N_SRC*ROB_BIT-1:0] req_q_i,
    input  logic [N_SRC*DAT_W-1:0]   req_v_i,
    input  logic [N_SRC-1:0]         req_cbr_i,
    input  logic [N_SRC*DAT_W-1:0]   req_cbt_i,
    output logic [N_SRC-1:0]         req_rdy_o,
    output logic                     cdb_en_o,
    output logic [ROB_BIT-1:0]       cdb_q_o,
    output logic [DAT_W-1:0]         cdb_v_o,
    output logic                     cdb_cbr_o,
    output logic [DAT_W-1:0]         cdb_cbt_o,
    output logic [SRC_BIT-1:0]       cdb_src_o,
    output logic                     err_o
);

    logic [SRC_BIT-1:0] rr_ptr;
    logic [SRC_BIT-1:0] gnt_idx;
    logic [SRC_BIT-1:0] next_ptr;
    logic               found;
    int                 j;
    logic [ROB_BIT-1:0] sel_q;
    logic [DAT_W-1:0]   sel_v;
    logic               sel_cbr;
    logic [DAT_W-1:0]   sel_cbt;

    // Search from rr_ptr upward with wrap; the first valid source found wins the bus.
    always_comb begin
        req_rdy_o = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        j         = 0;
        if (en && !flush_i && !rst) begin
            for (int k = 0; k < N_SRC; k++) begin
                j = int'(rr_ptr) + k;
                if (j >= N_SRC) j = j - N_SRC;
                if (!found && req_vld_i[j[SRC_BIT-1:0]]) begin
                    found   = 1'b1;
                    gnt_idx = j[SRC_BIT-1:0];
                end
            end
            if (found) req_rdy_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_q    = req_q_i[int'(gnt_idx)*ROB_BIT +: ROB_BIT];
        sel_v    = req_v_i[int'(gnt_idx)*DAT_W +: DAT_W];
        sel_cbr  = req_cbr_i[gnt_idx];
        sel_cbt  = req_cbt_i[int'(gnt_idx)*DAT_W +: DAT_W];
        next_ptr = (gnt_idx == SRC_BIT'(N_SRC - 1)) ? '0 : gnt_idx + SRC_BIT'(1);
    end

    // Tag-0 transfers are consumed and flagged but never reach the bus, so payload regs hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            cdb_en_o  <= 1'b0;
            cdb_q_o   <= '0;
            cdb_v_o   <= '0;
            cdb_cbr_o <= 1'b0;
            cdb_cbt_o <= '0;
            cdb_src_o <= '0;
            err_o     <= 1'b0;
        end else if (flush_i) begin
            cdb_en_o <= 1'b0;
            rr_ptr   <= '0;
        end else if (en && found) begin
            rr_ptr <= next_ptr;
            if (sel_q != '0) begin
                cdb_en_o  <= 1'b1;
                cdb_q_o   <= sel_q;
                cdb_v_o   <= sel_v;
                cdb_cbr_o <= sel_cbr;
                cdb_cbt_o <= sel_cbt;
                cdb_src_o <= gnt_idx;
            end else begin
                cdb_en_o <= 1'b0;
                err_o    <= 1'b1;
            end
        end else begin
            cdb_en_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized bench for cdb_arbiter, checked against a cycle-level model of the
// round-robin grant and one-deep broadcast rules.
module tb_cdb_arbiter;
    localparam int N_SRC   = 3;
    localparam int SRC_BIT = 2;
    localparam int ROB_BIT = 4;
    localparam int DAT_W   = 32;

    logic                     clk = 1'b0;
    logic                     rst, en, flush_i;
    logic [N_SRC-1:0]         req_vld_i;
    logic [N_SRC*ROB_BIT-1:0] req_q_i;
    logic [N_SRC*DAT_W-1:0]   req_v_i;
    logic [N_SRC-1:0]         req_cbr_i;
    logic [N_SRC*DAT_W-1:0]   req_cbt_i;
    logic [N_SRC-1:0]         req_rdy_o;
    logic                     cdb_en_o;
    logic [ROB_BIT-1:0]       cdb_q_o;
    logic [DAT_W-1:0]         cdb_v_o;
    logic                     cdb_cbr_o;
    logic [DAT_W-1:0]         cdb_cbt_o;
    logic [SRC_BIT-1:0]       cdb_src_o;
    logic                     err_o;

    cdb_arbiter #(.N_SRC(N_SRC), .SRC_BIT(SRC_BIT), .ROB_BIT(ROB_BIT), .DAT_W(DAT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
        .req_vld_i(req_vld_i), .req_q_i(req_q_i), .req_v_i(req_v_i),
        .req_cbr_i(req_cbr_i), .req_cbt_i(req_cbt_i), .req_rdy_o(req_rdy_o),
        .cdb_en_o(cdb_en_o), .cdb_q_o(cdb_q_o), .cdb_v_o(cdb_v_o),
        .cdb_cbr_o(cdb_cbr_o), .cdb_cbt_o(cdb_cbt_o), .cdb_src_o(cdb_src_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: pointer as a plain integer and the broadcast the bus should show.
    int            m_ptr = 0;
    bit            m_en  = 0;
    int unsigned   m_q = 0, m_v = 0, m_cbt = 0, m_src = 0;
    bit            m_cbr = 0, m_err = 0;
    int            last_grant = -1;
    logic [N_SRC-1:0] last_rdy;

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit f, input logic [N_SRC-1:0] vld);
        rst = r; en = e; flush_i = f; req_vld_i = vld;
    endtask

    task automatic setSrc(input int i, input logic [ROB_BIT-1:0] q, input logic [DAT_W-1:0] v,
                          input bit cbr, input logic [DAT_W-1:0] cbt);
        req_q_i[i*ROB_BIT +: ROB_BIT] = q;
        req_v_i[i*DAT_W +: DAT_W]     = v;
        req_cbr_i[i]                  = cbr;
        req_cbt_i[i*DAT_W +: DAT_W]   = cbt;
    endtask

    // One clock: check the combinational grant, advance the model, check registered outputs.
    task automatic doCycle(input string tag);
        int g;
        logic [N_SRC-1:0] exp_rdy;
        #2;
        g = -1;
        if (!rst && en && !flush_i)
            for (int k = 0; k < N_SRC; k++)
                if (g < 0 && req_vld_i[(m_ptr + k) % N_SRC]) g = (m_ptr + k) % N_SRC;
        exp_rdy  = (g >= 0) ? N_SRC'(1 << g) : '0;
        last_rdy = req_rdy_o;
        checkOutput({tag, "_rdy"}, 64'(req_rdy_o), 64'(exp_rdy));
        if (rst) begin
            m_ptr = 0; m_en = 0; m_q = 0; m_v = 0; m_cbr = 0; m_cbt = 0; m_src = 0; m_err = 0;
        end else if (flush_i) begin
            m_en = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N_SRC;
            if (req_q_i[g*ROB_BIT +: ROB_BIT] == 0) begin
                m_en = 0; m_err = 1;
            end else begin
                m_en  = 1;
                m_q   = req_q_i[g*ROB_BIT +: ROB_BIT];
                m_v   = req_v_i[g*DAT_W +: DAT_W];
                m_cbr = req_cbr_i[g];
                m_cbt = req_cbt_i[g*DAT_W +: DAT_W];
                m_src = g;
            end
        end else begin
            m_en = 0;
        end
        last_grant = g;
        @(posedge clk);
        #1;
        checkOutput({tag, "_en"},  64'(cdb_en_o),  64'(m_en));
        checkOutput({tag, "_err"}, 64'(err_o),     64'(m_err));
        checkOutput({tag, "_q"},   64'(cdb_q_o),   64'(m_q));
        checkOutput({tag, "_v"},   64'(cdb_v_o),   64'(m_v));
        checkOutput({tag, "_cbr"}, 64'(cdb_cbr_o), 64'(m_cbr));
        checkOutput({tag, "_cbt"}, 64'(cdb_cbt_o), 64'(m_cbt));
        checkOutput({tag, "_src"}, 64'(cdb_src_o), 64'(m_src));
    endtask

    initial begin
        int q_now [N_SRC];
        req_q_i = '0; req_v_i = '0; req_cbr_i = '0; req_cbt_i = '0;

        // Reset with all sources requesting: no grant may leak out during reset.
        applyStimulus(1, 1, 0, 3'b111);
        for (int i = 0; i < N_SRC; i++) setSrc(i, ROB_BIT'(i + 1), $urandom, 1'b1, $urandom);
        doCycle("rst");
        checkOutput("rst_rdy_zero", 64'(last_rdy), 64'(0));
        doCycle("rst");
        applyStimulus(0, 1, 0, 3'b000);
        for (int c = 0; c < 10; c++) doCycle("idle");
        checkOutput("idle_err", 64'(err_o), 64'(0));

        // Single source.
        applyStimulus(0, 1, 0, 3'b010);
        setSrc(1, 4'd5, 32'h1234, 1'b0, 32'h0);
        doCycle("single");
        checkOutput("single_rdy_T", 64'(last_rdy), 64'(3'b010));
        checkOutput("single_en_T1", 64'(cdb_en_o), 64'(1));
        checkOutput("single_q_T1", 64'(cdb_q_o), 64'(5));
        checkOutput("single_v_T1", 64'(cdb_v_o), 64'(32'h1234));
        checkOutput("single_src_T1", 64'(cdb_src_o), 64'(1));
        applyStimulus(0, 1, 0, 3'b000);
        doCycle("single_after");
        checkOutput("single_en_T2", 64'(cdb_en_o), 64'(0));

        // Flush to put the pointer back at 0, then fairness with tags 1..6.
        applyStimulus(0, 1, 1, 3'b000);
        doCycle("prefair_flush");
        for (int i = 0; i < N_SRC; i++) begin
            q_now[i] = i + 1;
            setSrc(i, ROB_BIT'(q_now[i]), $urandom, 1'($urandom), $urandom);
        end
        applyStimulus(0, 1, 0, 3'b111);
        for (int c = 0; c < 6; c++) begin
            doCycle("fair");
            checkOutput("fair_grant", 64'(last_rdy), 64'(1 << (c % N_SRC)));
            checkOutput("fair_en", 64'(cdb_en_o), 64'(1));
            checkOutput("fair_tag", 64'(cdb_q_o), 64'(c + 1));
            q_now[c % N_SRC] += N_SRC;
            setSrc(c % N_SRC, ROB_BIT'(q_now[c % N_SRC]), $urandom, 1'($urandom), $urandom);
        end

        // Flush drops the cycle after a grant from source 2.
        applyStimulus(0, 1, 0, 3'b100);
        setSrc(2, 4'd7, 32'hCAFE, 1'b1, 32'h80);
        doCycle("flush_T");
        checkOutput("flush_rdy_T", 64'(last_rdy), 64'(3'b100));
        checkOutput("flush_q_T1", 64'(cdb_q_o), 64'(7));
        applyStimulus(0, 1, 1, 3'b011);
        doCycle("flush_T1");
        checkOutput("flush_rdy_T1", 64'(last_rdy), 64'(0));
        checkOutput("flush_en_T2", 64'(cdb_en_o), 64'(0));
        applyStimulus(0, 1, 0, 3'b011);
        doCycle("flush_next");
        checkOutput("flush_next_grant", 64'(last_rdy), 64'(3'b001));

        // Stall for three cycles, then exactly one transfer.
        applyStimulus(0, 0, 0, 3'b001);
        setSrc(0, 4'd9, 32'h55, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            doCycle("stall");
            checkOutput("stall_rdy", 64'(last_rdy), 64'(0));
            checkOutput("stall_en", 64'(cdb_en_o), 64'(0));
        end
        applyStimulus(0, 1, 0, 3'b001);
        doCycle("unstall");
        checkOutput("unstall_q", 64'(cdb_q_o), 64'(9));
        applyStimulus(0, 1, 0, 3'b000);
        doCycle("unstall_after");
        checkOutput("unstall_once", 64'(cdb_en_o), 64'(0));

        // Tag 0 is consumed silently and raises the sticky error.
        applyStimulus(0, 1, 0, 3'b100);
        setSrc(2, 4'd0, 32'hDEAD, 1'b0, 32'h0);
        doCycle("tag0");
        checkOutput("tag0_rdy", 64'(last_rdy), 64'(3'b100));
        checkOutput("tag0_en", 64'(cdb_en_o), 64'(0));
        checkOutput("tag0_err", 64'(err_o), 64'(1));
        applyStimulus(0, 1, 1, 3'b000);
        doCycle("tag0_flush");
        checkOutput("tag0_err_kept", 64'(err_o), 64'(1));

        // Randomized traffic; granted sources present a fresh payload, others hold theirs.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_SRC; i++)
                if (last_grant == i || !req_vld_i[i])
                    setSrc(i, ROB_BIT'($urandom_range(0, 15)), $urandom, 1'($urandom), $urandom);
            applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 99) < 5), N_SRC'($urandom));
            doCycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
